fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 159 +++++++++++++++
 tb/tb_fetch_unit.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_fifo: small generic FIFO with synchronous flush; head is visible combinationally.
// Latency: a push is visible at the head on the cycle after it is written.
// Backpressure: none internally; the producer must never push when full.
module fetch_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         flush,
   input  logic                         push,
   input  logic [W-1:0]                 push_dat,
   input  logic                         pop,
   output logic [W-1:0]                 head_dat,
   output logic [$clog2(DEPTH+1)-1:0]   count
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH+1);

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
   endfunction

   assign head_dat = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= push_dat;
            wr_ptr      <= ptr_inc(wr_ptr);
         end
         if (pop) rd_ptr <= ptr_inc(rd_ptr);
         count <= count + CW'(push) - CW'(pop);
      end
   end
endmodule

// fetch_unit: instruction fetch with PC, one outstanding memory read and a 2-entry output FIFO.
// Latency: first issue in the first RUN cycle, instruction valid two cycles later; 1 instr/cycle steady state.
// Backpressure: stall holds the FIFO head; issue stops once FIFO + in-flight occupancy reaches 2.
// Ports: clk/rst (async active-low); start, stall, redirect/redirect_pc control;
//        imem_en/imem_addr/imem_rdata memory read port (data one cycle after enable);
//        instr/valid/instr_pc delivered instruction; halted high in HALT state.
module fetch_unit #(
   parameter int              ADDR_W      = 8,
   parameter logic [ADDR_W-1:0] RESET_PC  = '0,
   parameter logic [3:0]      HALT_OPCODE = 4'hF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              stall,
   input  logic              redirect,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              imem_en,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [7:0]        imem_rdata,
   output logic [7:0]        instr,
   output logic              valid,
   output logic [ADDR_W-1:0] instr_pc,
   output logic              halted
);
   typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

   typedef struct packed {
      logic [7:0]        instr;
      logic [ADDR_W-1:0] pc;
   } entry_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic              inflight_q;
   logic [ADDR_W-1:0] inflight_pc_q;

   entry_t            head;
   entry_t            push_entry;
   logic [1:0]        count;
   logic [2:0]        occ;
   logic              pop, halt_pop, flush, push, issue, room;

   assign valid    = (count != 2'd0);
   assign instr    = head.instr;
   assign instr_pc = head.pc;
   assign halted   = (state_q == HALT);

   assign pop      = valid && !stall;
   // Redirect outranks a halting pop: the halt byte is flushed along with everything else.
   assign halt_pop = pop && (head.instr[7:4] == HALT_OPCODE) && !redirect;
   assign flush    = redirect || halt_pop;

   // The read issued last cycle returns now; it is dropped if this cycle flushes.
   assign push             = inflight_q && !flush;
   assign push_entry.instr = imem_rdata;
   assign push_entry.pc    = inflight_pc_q;

   // Occupancy as it will stand next cycle before any new issue; keeps the FIFO from overflowing.
   assign occ   = {1'b0, count} + {2'b00, inflight_q};
   assign room  = (occ - {2'b00, pop}) < 3'd2;
   assign issue = (state_q == RUN) && !redirect && !halt_pop && room;

   assign imem_en   = issue;
   assign imem_addr = issue ? pc_q : '0;

   fetch_fifo #(.W($bits(entry_t)), .DEPTH(2)) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .push     (push),
      .push_dat (push_entry),
      .pop      (pop),
      .head_dat (head),
      .count    (count)
   );

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      if (redirect) begin
         pc_d = redirect_pc;
      end else if (halt_pop) begin
         pc_d    = instr_pc + ADDR_W'(1);
         state_d = HALT;
      end else begin
         if (issue) pc_d = pc_q + ADDR_W'(1);
         case (state_q)
            IDLE, HALT: if (start) state_d = RUN;
            RUN:        state_d = RUN;
            default:    state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= IDLE;
         pc_q          <= RESET_PC;
         inflight_q    <= 1'b0;
         inflight_pc_q <= '0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         inflight_q <= issue;
         if (issue) inflight_pc_q <= pc_q;
      end
   end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a scoreboard queue holds the expected delivered
// (byte, address) pairs; a negedge monitor pops and compares on every accepted instruction.
module tb_fetch_unit;
   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start = 1'b0;
   logic       stall = 1'b0;
   logic       redirect = 1'b0;
   logic [7:0] redirect_pc = 8'h00;
   logic       imem_en;
   logic [7:0] imem_addr;
   logic [7:0] imem_rdata = 8'h00;
   logic [7:0] instr;
   logic       valid;
   logic [7:0] instr_pc;
   logic       halted;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic [7:0] b;
      logic [7:0] pc;
   } exp_t;
   exp_t q[$];

   logic [7:0] mem [256];

   fetch_unit #(.ADDR_W(8), .RESET_PC(8'h00), .HALT_OPCODE(4'hF)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .stall       (stall),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .imem_en     (imem_en),
      .imem_addr   (imem_addr),
      .imem_rdata  (imem_rdata),
      .instr       (instr),
      .valid       (valid),
      .instr_pc    (instr_pc),
      .halted      (halted)
   );

   always #5 clk = ~clk;

   // Synchronous-read instruction memory: data one cycle after the strobe.
   always @(posedge clk) if (imem_en) imem_rdata <= mem[imem_addr];

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_instr(input logic [7:0] b, input logic [7:0] pc);
      exp_t e;
      e.b  = b;
      e.pc = pc;
      q.push_back(e);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic wait_halt();
      int n;
      n = 0;
      while (!halted && n < 40) begin
         step();
         n++;
      end
      check("halt_reached", int'(halted), 1);
      check("halt_imem_en", int'(imem_en), 0);
      check("halt_valid", int'(valid), 0);
   endtask

   // Scoreboard monitor: every accepted instruction must match the queue head.
   always @(negedge clk) begin
      if (rst && valid && !stall) begin
         if (q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL sb_unexpected: got instr 0x%0h pc 0x%0h, expected nothing", instr, instr_pc);
         end else begin
            exp_t e;
            e = q.pop_front();
            check("sb_instr", int'(instr), int'(e.b));
            check("sb_pc", int'(instr_pc), int'(e.pc));
         end
      end
   end

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      mem[8'h00] = 8'h11; mem[8'h01] = 8'h22; mem[8'h02] = 8'h33; mem[8'h03] = 8'hF5;
      mem[8'h04] = 8'h44; mem[8'h05] = 8'h55; mem[8'h06] = 8'h66;
      mem[8'h40] = 8'hA0; mem[8'h41] = 8'hF1; mem[8'hFF] = 8'h77;

      // Reset state
      step(); step();
      check("rst_valid", int'(valid), 0);
      check("rst_instr", int'(instr), 0);
      check("rst_instr_pc", int'(instr_pc), 0);
      check("rst_imem_en", int'(imem_en), 0);
      check("rst_imem_addr", int'(imem_addr), 0);
      check("rst_halted", int'(halted), 0);
      rst = 1'b1;
      step(); step();
      check("idle_imem_en", int'(imem_en), 0);

      // Basic fetch, stall on 0x22, then halt on 0xF5 at address 3
      expect_instr(8'h11, 8'h00); expect_instr(8'h22, 8'h01);
      expect_instr(8'h33, 8'h02); expect_instr(8'hF5, 8'h03);
      pulse_start();                                   // cycle N: first RUN cycle
      check("first_issue_en", int'(imem_en), 1);
      check("first_issue_addr", int'(imem_addr), 0);
      step();                                          // N+1
      check("lat_valid_n1", int'(valid), 0);
      step();                                          // N+2
      check("lat_valid_n2", int'(valid), 1);
      check("lat_instr_n2", int'(instr), 8'h11);
      step();                                          // N+3: head is 0x22
      stall = 1'b1;
      #1;
      for (int i = 0; i < 5; i++) begin
         check("stall_valid", int'(valid), 1);
         check("stall_instr", int'(instr), 8'h22);
         check("stall_pc", int'(instr_pc), 8'h01);
         check("stall_no_issue", int'(imem_en), 0);
         step();
      end
      stall = 1'b0;
      wait_halt();

      // Resume from 4, then redirect to 0x40 with one entry queued and one read in flight
      expect_instr(8'h44, 8'h04); expect_instr(8'hA0, 8'h40); expect_instr(8'hF1, 8'h41);
      pulse_start();                                   // T+1
      check("resume_addr", int'(imem_addr), 8'h04);
      step(); step();                                  // T+3: 0x44 accepted
      step();                                          // T+4
      stall = 1'b1;
      redirect = 1'b1;
      redirect_pc = 8'h40;
      #1;
      check("redir_head_instr", int'(instr), 8'h55);
      check("redir_no_issue", int'(imem_en), 0);
      step();                                          // T+5
      redirect = 1'b0;
      stall = 1'b0;
      #1;
      check("redir_valid_next", int'(valid), 0);
      check("redir_issue_addr", int'(imem_addr), 8'h40);
      wait_halt();

      // PC wrap: redirect while halted to 0xFF, then restart
      redirect = 1'b1;
      redirect_pc = 8'hFF;
      step();
      redirect = 1'b0;
      check("redir_halt_kept", int'(halted), 1);
      expect_instr(8'h77, 8'hFF); expect_instr(8'h11, 8'h00); expect_instr(8'h22, 8'h01);
      expect_instr(8'h33, 8'h02); expect_instr(8'hF5, 8'h03);
      pulse_start();
      check("wrap_issue_addr", int'(imem_addr), 8'hFF);
      wait_halt();

      // Reset asserted with a read in flight
      pulse_start();                                   // U+1: issue addr 4
      step();                                          // U+2: read of 4 in flight
      check("inflight_en", int'(imem_en), 1);
      rst = 1'b0;
      #1;
      check("midrst_valid", int'(valid), 0);
      check("midrst_instr", int'(instr), 0);
      check("midrst_instr_pc", int'(instr_pc), 0);
      check("midrst_imem_en", int'(imem_en), 0);
      check("midrst_imem_addr", int'(imem_addr), 0);
      check("midrst_halted", int'(halted), 0);
      step(); step();
      rst = 1'b1;
      step(); step();
      check("postrst_valid", int'(valid), 0);

      // Unstalled run after reset: one instruction per cycle from RESET_PC
      expect_instr(8'h11, 8'h00); expect_instr(8'h22, 8'h01);
      expect_instr(8'h33, 8'h02); expect_instr(8'hF5, 8'h03);
      pulse_start();                                   // N
      check("postrst_addr", int'(imem_addr), 8'h00);
      step(); step();                                  // N+2
      check("seq_instr0", int'(instr), 8'h11);
      step();
      check("seq_instr1", int'(instr), 8'h22);
      step();
      check("seq_instr2", int'(instr), 8'h33);
      step();
      check("seq_instr3", int'(instr), 8'hF5);
      check("seq_pc3", int'(instr_pc), 8'h03);
      step();
      check("seq_halted", int'(halted), 1);
      step(); step();
      check("sb_drained", q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end
endmodule
